// File: rtl/zcted_timing_nco.sv
// Modulo-1 timing NCO for the ZCTED symbol-timing loop: decrements a fractional phase per sample,
// emits an interpolant strobe with mu on each underflow, and tracks loop lock from |v_k|.
module zcted_timing_nco #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    NCO_WIDTH  = 16,
   parameter int                    OSR_LOG2   = 1,
   parameter int                    V_SHIFT    = 0,
   parameter logic [DATA_WIDTH-1:0] LOCK_THR   = 16'h0040,
   parameter int                    LOCK_LEN   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] v_k,
   output logic                  strobe,
   output logic [NCO_WIDTH-1:0]  mu,
   output logic                  on_time,
   output logic                  locked
);

   localparam int SW = NCO_WIDTH + 2;
   localparam int MW = NCO_WIDTH + OSR_LOG2;
   localparam int CW = $clog2(LOCK_LEN + 1);
   localparam logic signed [SW-1:0] W_NOM = SW'(1) <<< (NCO_WIDTH - OSR_LOG2);
   localparam logic signed [SW-1:0] W_MIN = SW'(1);
   localparam logic signed [SW-1:0] W_MAX = (SW'(1) <<< NCO_WIDTH) - SW'(1);
   localparam logic [CW-1:0]        CNT_MAX = CW'(LOCK_LEN);
   localparam logic [DATA_WIDTH-1:0] V_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] V_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

   state_t                 state_reg;
   logic [NCO_WIDTH-1:0]   eta_reg;
   logic                   next_on_time_reg;
   logic [CW-1:0]          lock_cnt_reg;

   logic signed [DATA_WIDTH-1:0] v_sh;
   logic signed [SW-1:0]   w_raw;
   logic signed [SW-1:0]   w_clamp;
   logic signed [SW-1:0]   d;
   logic                   underflow;
   logic [MW-1:0]          mu_wide;
   logic [NCO_WIDTH-1:0]   mu_sat;
   logic [DATA_WIDTH-1:0]  v_abs;
   logic                   quiet;
   logic                   noisy_strobe;

   always_comb begin
      v_sh    = $signed(v_k) >>> V_SHIFT;
      w_raw   = W_NOM + $signed({{(SW-DATA_WIDTH){v_sh[DATA_WIDTH-1]}}, v_sh});
      w_clamp = w_raw;
      if (w_raw < W_MIN)
         w_clamp = W_MIN;
      else if (w_raw > W_MAX)
         w_clamp = W_MAX;
      d         = $signed({2'b00, eta_reg}) - w_clamp;
      underflow = d[SW-1];
      mu_wide   = MW'(eta_reg) << OSR_LOG2;
      mu_sat    = (mu_wide > MW'({NCO_WIDTH{1'b1}})) ? {NCO_WIDTH{1'b1}} : mu_wide[NCO_WIDTH-1:0];
      // The most negative word has no positive twin, so its magnitude pins to max positive.
      if (v_k == V_MIN)
         v_abs = V_MAX;
      else if (v_k[DATA_WIDTH-1])
         v_abs = -v_k;
      else
         v_abs = v_k;
      quiet        = (v_abs <= LOCK_THR);
      noisy_strobe = sample_valid && underflow && !quiet;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         eta_reg          <= {NCO_WIDTH{1'b1}};
         next_on_time_reg <= 1'b1;
         lock_cnt_reg     <= '0;
         strobe           <= 1'b0;
         mu               <= '0;
         on_time          <= 1'b0;
         locked           <= 1'b0;
      end else if (!en) begin
         state_reg        <= IDLE;
         eta_reg          <= {NCO_WIDTH{1'b1}};
         next_on_time_reg <= 1'b1;
         lock_cnt_reg     <= '0;
         strobe           <= 1'b0;
         mu               <= '0;
         on_time          <= 1'b0;
         locked           <= 1'b0;
      end else begin
         strobe <= 1'b0;
         if (state_reg == IDLE) begin
            state_reg <= TRACK;
         end else begin
            if (sample_valid) begin
               // d modulo 2^NCO_WIDTH is the wrapped phase whether or not it underflowed.
               eta_reg <= d[NCO_WIDTH-1:0];
               if (underflow) begin
                  strobe           <= 1'b1;
                  mu               <= mu_sat;
                  on_time          <= next_on_time_reg;
                  next_on_time_reg <= ~next_on_time_reg;
                  if (!quiet)
                     lock_cnt_reg <= '0;
                  else if (lock_cnt_reg != CNT_MAX)
                     lock_cnt_reg <= lock_cnt_reg + CW'(1);
               end
            end
            if (state_reg == TRACK && lock_cnt_reg == CNT_MAX && !noisy_strobe) begin
               state_reg <= LOCKED;
               locked    <= 1'b1;
            end else if (state_reg == LOCKED && noisy_strobe) begin
               state_reg <= TRACK;
               locked    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_zcted_timing_nco.sv
// Directed and randomized checks of zcted_timing_nco against an integer-arithmetic phase/lock model.
module tb_zcted_timing_nco;

   logic        clk;
   logic        rst;
   logic        en;
   logic        sample_valid;
   logic [15:0] v_k;
   logic        strobe;
   logic [15:0] mu;
   logic        on_time;
   logic        locked;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state, plain integers.
   bit m_active;
   int m_eta;
   bit m_next_ot;
   int m_cnt;
   bit m_lock;
   bit e_strobe;
   int e_mu;
   bit e_ot;
   int strobe_count;

   zcted_timing_nco dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_valid (sample_valid),
      .v_k          (v_k),
      .strobe       (strobe),
      .mu           (mu),
      .on_time      (on_time),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active  = 0;
      m_eta     = 65535;
      m_next_ot = 1;
      m_cnt     = 0;
      m_lock    = 0;
      e_strobe  = 0;
      e_mu      = 0;
      e_ot      = 0;
   endtask

   task automatic model_cycle(input bit e, input bit s, input logic [15:0] v);
      int  vs, w, a;
      bit  uf, q;
      if (!e) begin
         model_reset();
         return;
      end
      e_strobe = 0;
      if (!m_active) begin
         m_active = 1;
         return;
      end
      vs = int'($signed(v));
      a  = (vs == -32768) ? 32767 : ((vs < 0) ? -vs : vs);
      q  = (a <= 64);
      uf = 0;
      if (s) begin
         w = 32768 + vs;
         if (w < 1) w = 1;
         if (w > 65535) w = 65535;
         uf = (m_eta < w);
      end
      // Lock decision looks at the quiet-strobe count accumulated so far.
      if (!m_lock && m_cnt == 64 && !(uf && !q))
         m_lock = 1;
      else if (m_lock && uf && !q)
         m_lock = 0;
      if (s) begin
         if (!uf) begin
            m_eta = m_eta - w;
         end else begin
            e_mu      = (m_eta * 2 > 65535) ? 65535 : m_eta * 2;
            e_ot      = m_next_ot;
            m_next_ot = !m_next_ot;
            e_strobe  = 1;
            m_eta     = m_eta + 65536 - w;
            m_cnt     = q ? ((m_cnt < 64) ? m_cnt + 1 : 64) : 0;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".strobe"}, 32'(strobe), 32'(e_strobe));
      chk({tag, ".mu"}, 32'(mu), 32'(e_mu));
      chk({tag, ".on_time"}, 32'(on_time), 32'(e_ot));
      chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
   endtask

   task automatic step(input string tag, input bit e, input bit s, input logic [15:0] v);
      en = e;
      sample_valid = s;
      v_k = v;
      model_cycle(e, s, v);
      @(posedge clk);
      #1;
      check_outputs(tag);
      if (strobe === 1'b1) strobe_count++;
   endtask

   initial begin
      int   lim;
      bit   sv;
      logic [15:0] vr;

      clk = 0; rst = 1; en = 0; sample_valid = 0; v_k = '0;
      strobe_count = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.strobe", 32'(strobe), 0);
      chk("reset.mu", 32'(mu), 0);
      chk("reset.on_time", 32'(on_time), 0);
      chk("reset.locked", 32'(locked), 0);
      rst = 0;
      $display("[TB] reset released");

      // Nominal step: strobe every second sample, mu=0xFFFE, on_time alternating.
      step("nominal", 1, 1, 16'h0000);
      for (int i = 0; i < 12; i++) step("nominal", 1, 1, 16'h0000);
      chk("nominal.last_mu", 32'(mu), 32'h0000_fffe);
      $display("[TB] nominal: %0d strobes", strobe_count);

      // Maximum step: strobe on every sample once wrapped, mu climbing by 2.
      step("wmax.off", 0, 0, 16'h0000);
      step("wmax.arm", 1, 1, 16'h7fff);
      for (int i = 0; i < 10; i++) step("wmax", 1, 1, 16'h7fff);
      chk("wmax.mu_after_10", 32'(mu), 32'h10);
      $display("[TB] wmax: mu=%0h", mu);

      // Minimum step clamps W to 1: one strobe after 0xFFFF quiet samples.
      step("wmin.off", 0, 0, 16'h0000);
      step("wmin.arm", 1, 1, 16'h8000);
      strobe_count = 0;
      for (int i = 0; i < 65535; i++) step("wmin", 1, 1, 16'h8000);
      chk("wmin.no_strobe_before", 32'(strobe_count), 0);
      step("wmin.wrap", 1, 1, 16'h8000);
      chk("wmin.wrap_strobe", 32'(strobe), 1);
      chk("wmin.wrap_mu", 32'(mu), 0);
      $display("[TB] wmin: wrap after 65536 samples");

      // Lock: 64 quiet strobes, then one noisy strobe.
      step("lock.off", 0, 0, 16'h0000);
      step("lock.arm", 1, 1, 16'h0010);
      strobe_count = 0;
      lim = 0;
      while (strobe_count < 64 && lim < 1000) begin
         step("lock", 1, 1, 16'h0010);
         lim++;
      end
      chk("lock.reached_64", 32'(strobe_count), 64);
      chk("lock.not_yet", 32'(locked), 0);
      step("lock.next", 1, 1, 16'h0010);
      chk("lock.asserted", 32'(locked), 1);
      strobe_count = 0;
      lim = 0;
      while (strobe_count < 1 && lim < 10) begin
         step("unlock", 1, 1, 16'h0100);
         lim++;
      end
      chk("unlock.strobe_seen", 32'(strobe_count), 1);
      chk("unlock.dropped", 32'(locked), 0);
      $display("[TB] lock/unlock sequence done");

      // Alternating sample_valid: phase frozen on the gaps.
      step("alt.off", 0, 0, 16'h0000);
      step("alt.arm", 1, 1, 16'h0000);
      for (int i = 0; i < 16; i++) step("alt", 1, (i % 2) == 0, 16'h1234);

      // en dropped for one cycle, then re-enable: first strobe has on_time=1.
      step("endrop.off", 0, 1, 16'h0000);
      chk("endrop.mu", 32'(mu), 0);
      step("endrop.arm", 1, 1, 16'h0000);
      step("endrop.a", 1, 1, 16'h0000);
      step("endrop.b", 1, 1, 16'h0000);
      chk("endrop.first_on_time", 32'(on_time), 1);

      // Asynchronous reset in mid-cycle.
      for (int i = 0; i < 5; i++) step("prerst", 1, 1, 16'h0300);
      #2 rst = 1;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(posedge clk);
      #1 rst = 0;
      step("postrst.arm", 1, 1, 16'h0000);
      step("postrst.a", 1, 1, 16'h0000);
      step("postrst.b", 1, 1, 16'h0000);
      chk("postrst.first_on_time", 32'(on_time), 1);
      $display("[TB] en drop and async reset done");

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 4))
            0:       vr = 16'($urandom_range(0, 128) - 64);
            1:       vr = 16'($urandom_range(0, 2048) - 1024);
            2:       vr = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7fff;
            default: vr = 16'($urandom_range(0, 40) - 20);
         endcase
         sv = ($urandom_range(0, 3) != 0);
         step("rand", ($urandom_range(0, 199) != 0), sv, vr);
      end
      $display("[TB] random phase done");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
